// File: rtl/maze_update_ctrl.sv
// Assembles three Arduino beats per cell into a 9-bit word and commits it to the cell RAM.
// Also tracks maze-done and latches sticky protocol errors, including inter-beat timeouts.
module maze_update_ctrl #(
    parameter int TIMEOUT_CYC = 250000,
    parameter int NUM_CELLS   = 20
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [2:0] ARD_DATA,
    input  logic       ARD_STROBE,
    input  logic [4:0] ARD_ADDR,
    input  logic       ERR_CLR,
    output logic [4:0] RAM_WADDR,
    output logic [8:0] RAM_WDATA,
    output logic       RAM_WE,
    output logic       DONE,
    output logic       FRAME_ERR,
    output logic [7:0] UPDATE_CNT
);

    localparam int         CW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [4:0] ADDR_SYNC = 5'd31;
    localparam logic [4:0] ADDR_DONE = 5'd30;

    typedef enum logic [2:0] {IDLE, B0, B1, B2, COMMIT} state_t;

    state_t        state, next_state;
    logic   [8:0]  sync1, sync2;
    logic          strobe_prev;
    logic          beat, cell_ok, in_frame, timeout;
    logic   [4:0]  b_addr, cell_addr, cell_addr_n;
    logic   [2:0]  b_data;
    logic   [8:0]  word, word_n;
    logic   [CW-1:0] tmo_cnt;
    logic          err_set, done_set, done_clr;

    // NOTE: synchronizer flops reset to 1 so a strobe already high at reset release is not an edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1       <= '1;
            sync2       <= '1;
            strobe_prev <= 1'b1;
        end else begin
            sync1       <= {ARD_STROBE, ARD_ADDR, ARD_DATA};
            sync2       <= sync1;
            strobe_prev <= sync2[8];
        end
    end

    assign beat     = sync2[8] & ~strobe_prev;
    assign b_addr   = sync2[7:3];
    assign b_data   = sync2[2:0];
    assign cell_ok  = (32'(b_addr) < NUM_CELLS);
    assign in_frame = (state == B0) || (state == B1) || (state == B2);
    assign timeout  = in_frame && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        word_n      = word;
        cell_addr_n = cell_addr;
        err_set     = 1'b0;
        done_set    = 1'b0;
        done_clr    = 1'b0;
        case (state)
            IDLE: if (beat) begin
                if (b_addr == ADDR_SYNC) begin
                    next_state = B0;
                    done_clr   = 1'b1;
                end else if (b_addr == ADDR_DONE) begin
                    done_set = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            B0: if (beat) begin
                if (b_addr == ADDR_SYNC) begin
                    next_state = B0;
                end else if (cell_ok) begin
                    cell_addr_n = b_addr;
                    word_n      = {6'b0, b_data};
                    next_state  = B1;
                end else begin
                    err_set    = 1'b1;
                    next_state = IDLE;
                end
            end else if (timeout) begin
                err_set    = 1'b1;
                next_state = IDLE;
            end
            B1: if (beat) begin
                if (b_addr == cell_addr) begin
                    word_n[5:3] = b_data;
                    next_state  = B2;
                end else if (b_addr == ADDR_SYNC) begin
                    next_state = B0;
                end else begin
                    err_set    = 1'b1;
                    next_state = IDLE;
                end
            end else if (timeout) begin
                err_set    = 1'b1;
                next_state = IDLE;
            end
            B2: if (beat) begin
                if (b_addr == cell_addr) begin
                    word_n[8:6] = b_data;
                    next_state  = COMMIT;
                end else if (b_addr == ADDR_SYNC) begin
                    next_state = B0;
                end else begin
                    err_set    = 1'b1;
                    next_state = IDLE;
                end
            end else if (timeout) begin
                err_set    = 1'b1;
                next_state = IDLE;
            end
            COMMIT: begin
                next_state = IDLE;
                err_set    = beat;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            word       <= '0;
            cell_addr  <= '0;
            tmo_cnt    <= '0;
            RAM_WE     <= 1'b0;
            RAM_WADDR  <= '0;
            RAM_WDATA  <= '0;
            UPDATE_CNT <= '0;
            DONE       <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state     <= next_state;
            word      <= word_n;
            cell_addr <= cell_addr_n;
            tmo_cnt   <= (beat || !in_frame) ? '0 : tmo_cnt + 1'b1;

            // The write is launched from COMMIT so a reset landing in COMMIT suppresses it.
            RAM_WE <= (state == COMMIT);
            if (state == COMMIT) begin
                RAM_WADDR  <= cell_addr;
                RAM_WDATA  <= word;
                UPDATE_CNT <= UPDATE_CNT + 8'd1;
            end

            if (done_set)      DONE <= 1'b1;
            else if (done_clr) DONE <= 1'b0;

            if (err_set)      FRAME_ERR <= 1'b1;
            else if (ERR_CLR) FRAME_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maze_update_ctrl.sv
// Randomized scoreboard bench for maze_update_ctrl against a protocol-level reference model.
module tb_maze_update_ctrl;

    localparam int T  = 64;
    localparam int NC = 20;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [2:0] ARD_DATA;
    logic       ARD_STROBE;
    logic [4:0] ARD_ADDR;
    logic       ERR_CLR;
    logic [4:0] RAM_WADDR;
    logic [8:0] RAM_WDATA;
    logic       RAM_WE;
    logic       DONE;
    logic       FRAME_ERR;
    logic [7:0] UPDATE_CNT;

    always #20 CLOCK = ~CLOCK;

    maze_update_ctrl #(.TIMEOUT_CYC(T), .NUM_CELLS(NC)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ARD_DATA(ARD_DATA), .ARD_STROBE(ARD_STROBE),
        .ARD_ADDR(ARD_ADDR), .ERR_CLR(ERR_CLR), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_WE(RAM_WE), .DONE(DONE), .FRAME_ERR(FRAME_ERR), .UPDATE_CNT(UPDATE_CNT)
    );

    typedef struct {
        logic [4:0] addr;
        logic [8:0] data;
        logic [7:0] cnt;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model: nibbles collected so far in the current frame (-1 = not in a frame).
    int         phase;
    logic [4:0] m_addr;
    logic [2:0] m_nib[3];
    logic       m_err, m_done;
    logic [7:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        phase  = -1;
        m_addr = '0;
        m_err  = 1'b0;
        m_done = 1'b0;
        m_cnt  = '0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input logic [4:0] a, input logic [2:0] d);
        wr_t w;
        if (phase < 0) begin
            if (a == 31) begin phase = 0; m_done = 1'b0; end
            else if (a == 30) m_done = 1'b1;
            else m_err = 1'b1;
        end else if (a == 31) begin
            phase = 0;
        end else if (phase == 0 && int'(a) < NC) begin
            m_addr   = a;
            m_nib[0] = d;
            phase    = 1;
        end else if (phase > 0 && a == m_addr) begin
            m_nib[phase] = d;
            phase++;
            if (phase == 3) begin
                m_cnt  = m_cnt + 8'd1;
                w.addr = m_addr;
                w.data = {m_nib[2], m_nib[1], m_nib[0]};
                w.cnt  = m_cnt;
                exp_q.push_back(w);
                phase  = -1;
            end
        end else begin
            m_err = 1'b1;
            phase = -1;
        end
    endfunction

    task automatic beat(input logic [4:0] a, input logic [2:0] d);
        @(negedge CLOCK);
        ARD_ADDR = a;
        ARD_DATA = d;
        repeat (2) @(negedge CLOCK);
        ARD_STROBE = 1'b1;
        model_beat(a, d);
        repeat (4) @(negedge CLOCK);
        ARD_STROBE = 1'b0;
        repeat (4) @(negedge CLOCK);
    endtask

    task automatic err_clear();
        @(negedge CLOCK);
        ERR_CLR = 1'b1;
        m_err   = 1'b0;
        @(negedge CLOCK);
        ERR_CLR = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_frame_err"}, 32'(FRAME_ERR), 32'(m_err));
        check({tag, "_done"}, 32'(DONE), 32'(m_done));
        check({tag, "_update_cnt"}, 32'(UPDATE_CNT), 32'(m_cnt));
    endtask

    // Monitor: every cycle with RAM_WE high must match the oldest expected write.
    always @(negedge CLOCK) begin
        wr_t w;
        if (RAM_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(RAM_WADDR), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(RAM_WADDR), 32'(w.addr));
                check("wr_data", 32'(RAM_WDATA), 32'(w.data));
                check("wr_cnt", 32'(UPDATE_CNT), 32'(w.cnt));
            end
        end
    end

    initial begin
        RESET = 1'b1; ARD_DATA = '0; ARD_STROBE = 1'b0; ARD_ADDR = '0; ERR_CLR = 1'b0;
        model_reset();
        repeat (4) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("rst_we", 32'(RAM_WE), 0);
        check("rst_waddr", 32'(RAM_WADDR), 0);
        check("rst_wdata", 32'(RAM_WDATA), 0);
        check_status("rst");

        // Basic frame
        beat(31, 0); beat(7, 3); beat(7, 5); beat(7, 2);
        check("f1_waddr", 32'(RAM_WADDR), 7);
        check("f1_wdata", 32'(RAM_WDATA), 32'(9'b010_101_011));
        check("f1_cnt", 32'(UPDATE_CNT), 1);
        check_status("f1");

        // Resync mid-frame discards the partial word
        beat(31, 0); beat(4, 1); beat(31, 0); beat(4, 6); beat(4, 0); beat(4, 7);
        check("f2_waddr", 32'(RAM_WADDR), 4);
        check("f2_wdata", 32'(RAM_WDATA), 32'(9'b111_000_110));
        check_status("f2");

        // Address mismatch, then error clear
        beat(31, 0); beat(2, 1); beat(3, 1);
        check("f3_err_set", 32'(FRAME_ERR), 1);
        check_status("f3");
        err_clear();
        @(negedge CLOCK);
        check("f3_err_clr", 32'(FRAME_ERR), 0);

        // Timeout aborts the frame; the next frame commits
        beat(31, 0); beat(9, 4); beat(9, 4);
        repeat (T + 10) @(negedge CLOCK);
        if (phase >= 0) begin m_err = 1'b1; phase = -1; end
        check("tmo_err", 32'(FRAME_ERR), 1);
        check_status("tmo");
        beat(31, 0); beat(9, 1); beat(9, 2); beat(9, 3);
        check("tmo_next_wdata", 32'(RAM_WDATA), 32'(9'b011_010_001));
        check_status("tmo_next");
        err_clear();

        // DONE handling
        beat(30, 0);
        check("done_set", 32'(DONE), 1);
        beat(31, 0);
        check("done_clr", 32'(DONE), 0);
        beat(22, 0);
        check("b0_bad_err", 32'(FRAME_ERR), 1);
        check_status("done");
        err_clear();

        // Randomized frames with occasional corrupted addresses and done beats
        for (int f = 0; f < 50; f++) begin
            logic [4:0] a, ba;
            a = 5'($urandom_range(0, NC - 1));
            beat(31, 3'($urandom));
            for (int k = 0; k < 3; k++) begin
                ba = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : a;
                beat(ba, 3'($urandom));
            end
            if ($urandom_range(0, 4) == 0) beat(30, 0);
            if (m_err && $urandom_range(0, 1) == 1) err_clear();
            check_status("rnd");
        end

        // Reset while the committed write is pending, strobe held high across release
        beat(31, 0); beat(5, 1); beat(5, 2);
        @(negedge CLOCK);
        ARD_ADDR = 5; ARD_DATA = 3;
        repeat (2) @(negedge CLOCK);
        ARD_STROBE = 1'b1;
        model_beat(5, 3);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        model_reset();
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (8) @(negedge CLOCK);
        check("rst2_we", 32'(RAM_WE), 0);
        check("rst2_waddr", 32'(RAM_WADDR), 0);
        check("rst2_wdata", 32'(RAM_WDATA), 0);
        check_status("rst2");
        ARD_STROBE = 1'b0;
        repeat (6) @(negedge CLOCK);
        check_status("rst2_rel");

        beat(31, 0); beat(19, 7); beat(19, 0); beat(19, 5);
        check("last_wdata", 32'(RAM_WDATA), 32'(9'b101_000_111));
        check_status("last");
        repeat (10) @(negedge CLOCK);
        check("missing_writes", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_update_ctrl.md
MAZE_UPDATE_CTRL -- requirements
Module: maze_update_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 250000, which sets the maximum number of CLOCK cycles allowed between beats inside a cell frame (10 ms at 25 MHz).
REQ-002 The block SHALL have parameter NUM_CELLS, default 20, giving the number of valid cell addresses (0..NUM_CELLS-1).
REQ-003 CLOCK  input  1  25 MHz pixel clock; every flop in the block is clocked on its rising edge.
REQ-004 RESET  input  1  reset; synchronous and active-high.
REQ-005 ARD_DATA  input  3  Arduino data nibble; asynchronous to CLOCK.
REQ-006 ARD_STROBE  input  1  Arduino beat strobe; asynchronous; a rising edge marks one beat.
REQ-007 ARD_ADDR  input  5  Arduino beat address; asynchronous; 31 = frame sync, 30 = maze done, 0..NUM_CELLS-1 = cell.
REQ-008 ERR_CLR  input  1  single-cycle pulse that clears FRAME_ERR.
REQ-009 RAM_WADDR  output  5  cell RAM write address.
REQ-010 RAM_WDATA  output  9  cell word: {state[8:6], walls[5:2], treasure[1:0]}.
REQ-011 RAM_WE  output  1  cell RAM write enable; one-cycle pulse.
REQ-012 DONE  output  1  maze-complete level; drives the tone generator enable.
REQ-013 FRAME_ERR  output  1  sticky protocol-error flag.
REQ-014 UPDATE_CNT  output  8  count of committed cell writes; wraps around.

Function
REQ-015 ARD_STROBE, ARD_DATA and ARD_ADDR SHALL each pass through a 2-flop synchronizer.
REQ-016 A beat SHALL be detected in the cycle where the synchronized strobe is 1 and its previous registered value is 0; data and address SHALL be sampled from the synchronized copies in that same cycle.
REQ-017 Latency SHALL be: an ARD_STROBE rising edge at the pin is detected 3 CLOCK cycles later.
REQ-018 The state machine SHALL have the states IDLE, B0, B1, B2 and COMMIT; transitions occur only on detected beats, on timeout, or on reset.
REQ-019 IDLE: addr 31 -> B0 and clear DONE; addr 30 -> set DONE and stay in IDLE; any other addr -> set FRAME_ERR and stay in IDLE.
REQ-020 B0: addr 31 -> stay in B0 (resync); addr < NUM_CELLS -> latch the addr, word[2:0]=data, go to B1; any other addr -> set FRAME_ERR and go to IDLE.
REQ-021 B1: addr equal to the latched addr -> word[5:3]=data, go to B2; addr 31 -> B0 and discard the partial word; any other addr -> set FRAME_ERR and go to IDLE.
REQ-022 B2: addr equal to the latched addr -> word[8:6]=data, go to COMMIT; addr 31 -> B0; any other addr -> set FRAME_ERR and go to IDLE.
REQ-023 COMMIT SHALL last exactly one cycle: RAM_WE=1, RAM_WADDR=latched addr, RAM_WDATA=assembled word, UPDATE_CNT increments (mod 256), then the state returns to IDLE.
REQ-024 RAM_WE, RAM_WADDR and RAM_WDATA SHALL be registered outputs; RAM_WADDR and RAM_WDATA SHALL hold their last committed values while RAM_WE=0.
REQ-025 Beats cannot occur on consecutive cycles, so no beat can coincide with COMMIT; if one is detected there anyway, it SHALL be ignored and FRAME_ERR set.
REQ-026 Timeout: a cycle counter SHALL run in B0, B1 and B2 and clear on every beat; when it reaches TIMEOUT_CYC-1, the state SHALL go to IDLE, FRAME_ERR SHALL be set and the partial word SHALL be discarded, with no RAM write.
REQ-027 If a timeout and a beat occur in the same cycle, the beat SHALL win.
REQ-028 FRAME_ERR SHALL stay set until ERR_CLR or RESET; if a new error and ERR_CLR occur in the same cycle, FRAME_ERR SHALL end set.
REQ-029 DONE SHALL change only in IDLE as defined in REQ-019; an addr-30 beat in B0, B1 or B2 is a protocol error (REQ-020 to REQ-022).

Reset
REQ-030 While RESET=1 at a CLOCK edge, the block SHALL go to IDLE and clear RAM_WE, RAM_WADDR, RAM_WDATA, DONE, FRAME_ERR, UPDATE_CNT, the timeout counter and the partial word.
REQ-031 Synchronizer and previous-strobe flops SHALL reset to 1, so a strobe held high through reset release does not produce a beat.
REQ-032 Reset during B0, B1, B2 or COMMIT SHALL abort the frame; no RAM_WE pulse may appear after the reset cycle.

Verification
REQ-033 Beats addr 31, then addr 7 with data 3, 5, 2 -> exactly one RAM_WE pulse, RAM_WADDR=7, RAM_WDATA=9'b010_101_011, UPDATE_CNT=1, FRAME_ERR=0.
REQ-034 Beats 31, 4(d=1), 31, 4(d=6), 4(d=0), 4(d=7) -> single write, addr 4, data 9'b111_000_110; no error.
REQ-035 Beats 31, 2, 3 -> FRAME_ERR=1, no write, state IDLE; then ERR_CLR pulse -> FRAME_ERR=0.
REQ-036 Beats 31, 9, 9, then no strobe for TIMEOUT_CYC cycles -> FRAME_ERR=1, no write; the next 31, 9, 9, 9 frame commits normally.
REQ-037 Beat 30 in IDLE -> DONE=1; beat 31 -> DONE=0; beat 22 in B0 -> FRAME_ERR=1 and DONE unchanged.
REQ-038 RESET asserted the cycle after the third beat is detected -> RAM_WE stays 0 and all outputs are 0; strobe held high across reset release -> no beat.
